// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: queues requested SR-flop levels and turns each into a legal S or R pulse plus idle gap.
// Optional readback check (q_fb input, sticky mismatch output) is enabled by defining SRDRV_READBACK_EN.
module sr_drive_sequencer #(
    parameter int PULSE_W = 1,
    parameter int GAP_W   = 1,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_level,
    input  logic             req_force,
`ifdef SRDRV_READBACK_EN
    input  logic             q_fb,
    output logic             mismatch,
`endif
    output logic             S,
    output logic             R,
    output logic             mirror_q,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PL = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] GL = TW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [1:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop, done;
    logic          head_level, head_force;
    logic          lvl, lvl_n, s_n, r_n;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign {head_level, head_force} = mem[rd_ptr[AW-1:0]];
    assign busy      = !empty || state != IDLE;

    // Request storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {req_level, req_force};
    end

    // FIFO pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Next-state logic: pop in IDLE, drop redundant entries, time the pulse and the gap
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        lvl_n   = lvl;
        s_n     = S;
        r_n     = R;
        pop     = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (head_force || head_level != mirror_q) begin
                    state_n = PULSE;
                    tmr_n   = '0;
                    lvl_n   = head_level;
                    s_n     = head_level;
                    r_n     = !head_level;
                end
            end
            PULSE: if (tmr == PL) begin
                state_n = GAP;
                tmr_n   = '0;
                s_n     = 1'b0;
                r_n     = 1'b0;
                done    = 1'b1;
            end else begin
                tmr_n = tmr + 1'b1;
            end
            GAP: if (tmr == GL) begin
                state_n = IDLE;
                tmr_n   = '0;
            end else begin
                tmr_n = tmr + 1'b1;
            end
            default: begin
                state_n = IDLE;
                s_n     = 1'b0;
                r_n     = 1'b0;
            end
        endcase
    end

    // State register with registered S/R drive so the flop only sees clean edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
            lvl   <= 1'b0;
            S     <= 1'b0;
            R     <= 1'b0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            lvl   <= lvl_n;
            S     <= s_n;
            R     <= r_n;
        end
    end

    // Mirror of the flop's Q and issued-pulse counter, both updated as a pulse ends
    always_ff @(posedge clk) begin
        if (reset) begin
            mirror_q  <= 1'b0;
            cmd_count <= '0;
        end else if (done) begin
            mirror_q  <= lvl;
            cmd_count <= cmd_count + 1'b1;
        end
    end

`ifdef SRDRV_READBACK_EN
    // Sticky readback check on the last gap cycle of every issued command
    always_ff @(posedge clk) begin
        if (reset) mismatch <= 1'b0;
        else if (state == GAP && tmr == GL && q_fb != mirror_q) mismatch <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb_sr_drive_sequencer: two sequencer configurations checked every cycle against a timeline model.
module tb_sr_drive_sequencer;
    localparam int CW = 8;
    localparam int D  = 4;
    localparam int P0 = 1, G0 = 1, P1 = 3, G1 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, valid = 1'b0, level = 1'b0, frc = 1'b0;
    logic rdy [2], s [2], r [2], mq [2], bsy [2];
    logic [CW-1:0] cnt [2];

    always #5 clk = ~clk;

`ifdef SRDRV_READBACK_EN
    logic flop [2], fb [2], mis [2];
    logic fb_zero = 1'b0;
    assign fb[0] = !fb_zero && flop[0];
    assign fb[1] = !fb_zero && flop[1];
    // Real SR flop driven by each DUT, feeding q_fb
    always @(posedge clk)
        for (int k = 0; k < 2; k++) flop[k] <= reset ? 1'b0 : s[k] ? 1'b1 : r[k] ? 1'b0 : flop[k];
`endif

    sr_drive_sequencer #(.PULSE_W(P0), .GAP_W(G0), .DEPTH(D), .CNT_W(CW)) u0 (
        .clk(clk), .reset(reset), .req_valid(valid), .req_ready(rdy[0]),
        .req_level(level), .req_force(frc),
`ifdef SRDRV_READBACK_EN
        .q_fb(fb[0]), .mismatch(mis[0]),
`endif
        .S(s[0]), .R(r[0]), .mirror_q(mq[0]), .busy(bsy[0]), .cmd_count(cnt[0]));

    sr_drive_sequencer #(.PULSE_W(P1), .GAP_W(G1), .DEPTH(D), .CNT_W(CW)) u1 (
        .clk(clk), .reset(reset), .req_valid(valid), .req_ready(rdy[1]),
        .req_level(level), .req_force(frc),
`ifdef SRDRV_READBACK_EN
        .q_fb(fb[1]), .mismatch(mis[1]),
`endif
        .S(s[1]), .R(r[1]), .mirror_q(mq[1]), .busy(bsy[1]), .cmd_count(cnt[1]));

    int e = 0, nvec = 0, nerr = 0;
    bit [1:0] mf [2][$];
    bit [1:0] acc [2][$];
    bit obs [2][$];
    int free_at [2] = '{0, 0};
    int hi_from [2] = '{1, 1};
    int hi_to [2]   = '{0, 0};
    int upd_at [2]  = '{-1, -1};
    int m_cnt [2]   = '{0, 0};
    int s_cyc [2]   = '{0, 0};
    int r_cyc [2]   = '{0, 0};
    bit plv [2], pulsed [2], m_mir [2], m_flop [2], m_mis [2], saw_nr [2];
    logic prev_s [2], prev_r [2];

    function automatic int pw(int k); return k == 0 ? P0 : P1; endfunction
    function automatic int gw(int k); return k == 0 ? G0 : G1; endfunction
    function automatic bit hi(int k, int x); return x >= hi_from[k] && x <= hi_to[k]; endfunction

    task automatic cmp(string nm, int k, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s[u%0d] edge %0d: got %0h expected %0h", nm, k, e, got, exp);
        end
    endtask

    // Advance the model across edge e using the inputs the DUT is about to sample
    task automatic model_step(int k);
        bit [1:0] h;
        bit fbv, ready;
        fbv = m_flop[k];
`ifdef SRDRV_READBACK_EN
        if (fb_zero) fbv = 1'b0;
`endif
        if (reset) begin
            mf[k].delete();
            m_mir[k] = 0; m_cnt[k] = 0; free_at[k] = 0; hi_from[k] = 1; hi_to[k] = 0;
            upd_at[k] = -1; pulsed[k] = 0; m_mis[k] = 0; m_flop[k] = 0;
            return;
        end
        if (pulsed[k] && e == free_at[k] - 1 && fbv != m_mir[k]) m_mis[k] = 1;
        if (hi(k, e - 1)) m_flop[k] = plv[k];
        if (e == upd_at[k]) begin m_mir[k] = plv[k]; m_cnt[k]++; end
        ready = mf[k].size() < D;
        if (e >= free_at[k] && mf[k].size() > 0) begin
            h = mf[k].pop_front();
            if (h[0] || h[1] != m_mir[k]) begin
                plv[k] = h[1]; pulsed[k] = 1;
                hi_from[k] = e; hi_to[k] = e + pw(k) - 1; upd_at[k] = e + pw(k);
                free_at[k] = e + pw(k) + gw(k) + 1;
            end else pulsed[k] = 0;
        end
        if (valid && ready) begin
            mf[k].push_back({level, frc});
            acc[k].push_back({level, frc});
        end
    endtask

    task automatic check(int k);
        bit h;
        h = hi(k, e);
        cmp("S", k, s[k], h && plv[k]);
        cmp("R", k, r[k], h && !plv[k]);
        cmp("S_and_R", k, s[k] && r[k], 1'b0);
        cmp("mirror_q", k, mq[k], m_mir[k]);
        cmp("cmd_count", k, cnt[k], m_cnt[k][CW-1:0]);
        cmp("req_ready", k, rdy[k], mf[k].size() < D);
        cmp("busy", k, bsy[k], mf[k].size() > 0 || e + 1 < free_at[k]);
`ifdef SRDRV_READBACK_EN
        cmp("mismatch", k, mis[k], m_mis[k]);
`endif
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k);
            if (s[k] === 1'b1 && prev_s[k] !== 1'b1) obs[k].push_back(1'b1);
            if (r[k] === 1'b1 && prev_r[k] !== 1'b1) obs[k].push_back(1'b0);
            if (s[k] === 1'b1) s_cyc[k]++;
            if (r[k] === 1'b1) r_cyc[k]++;
            if (rdy[k] === 1'b0) saw_nr[k] = 1;
            prev_s[k] = s[k];
            prev_r[k] = r[k];
        end
        e++;
    endtask

    task automatic drain();
        int n = 0;
        while ((bsy[0] !== 1'b0 || bsy[1] !== 1'b0) && n < 200) begin tick(); n++; end
        nvec++;
        if (n >= 200) begin
            nerr++;
            $display("FAIL drain: busy=%b/%b still set after %0d cycles, required 0", bsy[0], bsy[1], n);
        end
    endtask

    task automatic rst();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_cyc[k] = 0; r_cyc[k] = 0; saw_nr[k] = 0;
            acc[k].delete(); obs[k].delete();
        end
    endtask

    task automatic push1(bit l, bit f);
        valid = 1'b1; level = l; frc = f;
        tick();
        valid = 1'b0; frc = 1'b0;
    endtask

    initial begin
        bit [1:0] x;
        bit m;
        bit exp_q [$];
        // Reset state
        reset = 1'b1;
        tick();
        rst();
        for (int k = 0; k < 2; k++) begin
            cmp("rst_S", k, s[k], 0); cmp("rst_R", k, r[k], 0); cmp("rst_mq", k, mq[k], 0);
            cmp("rst_cnt", k, cnt[k], 0); cmp("rst_ready", k, rdy[k], 1); cmp("rst_busy", k, bsy[k], 0);
        end
        // Single set command: S high on the 2nd edge after the push, idle after the 4th
        push1(1'b1, 1'b0);
        cmp("t1_S_push", 0, s[0], 0);
        cmp("t1_busy", 0, bsy[0], 1);
        tick();
        cmp("t1_S_hi", 0, s[0], 1);
        cmp("t1_R_lo", 0, r[0], 0);
        cmp("t1_S_hi", 1, s[1], 1);
        tick();
        cmp("t1_S_end", 0, s[0], 0);
        cmp("t1_mq", 0, mq[0], 1);
        cmp("t1_cnt", 0, cnt[0], 1);
        tick();
        cmp("t1_idle", 0, bsy[0], 0);
        drain();
        cmp("t1_cnt", 1, cnt[1], 1);
        // 1,1,0 without force: middle entry is redundant
        rst();
        push1(1'b1, 1'b0);
        push1(1'b1, 1'b0);
        push1(1'b0, 1'b0);
        drain();
        for (int k = 0; k < 2; k++) begin
            cmp("t2_cnt", k, cnt[k], 2);
            cmp("t2_mq", k, mq[k], 0);
        end
        cmp("t2_s_cycles", 0, s_cyc[0], 1);
        cmp("t2_r_cycles", 0, r_cyc[0], 1);
        cmp("t2_s_cycles", 1, s_cyc[1], 3);
        cmp("t2_r_cycles", 1, r_cyc[1], 3);
        // Forced clear from reset still pulses R
        rst();
        push1(1'b0, 1'b1);
        drain();
        for (int k = 0; k < 2; k++) begin
            cmp("t3_cnt", k, cnt[k], 1);
            cmp("t3_mq", k, mq[k], 0);
            cmp("t3_s_cycles", k, s_cyc[k], 0);
        end
        cmp("t3_r_cycles", 0, r_cyc[0], 1);
        cmp("t3_r_cycles", 1, r_cyc[1], 3);
        // Back-pressure: hold valid while busy, then check pulse order on a scoreboard
        rst();
        valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            level = 1'(i % 3 != 1);
            frc = 1'(i % 7 == 5);
            tick();
        end
        valid = 1'b0; frc = 1'b0;
        drain();
        for (int k = 0; k < 2; k++) begin
            cmp("t4_backpressure", k, saw_nr[k], 1);
            exp_q.delete();
            m = 1'b0;
            foreach (acc[k][i]) begin
                x = acc[k][i];
                if (x[0] || x[1] != m) begin exp_q.push_back(x[1]); m = x[1]; end
            end
            cmp("t4_sb_len", k, obs[k].size(), exp_q.size());
            if (obs[k].size() == exp_q.size())
                foreach (exp_q[i]) cmp("t4_sb_order", k, obs[k][i], exp_q[i]);
        end
        // Reset in the 2nd cycle of a 3-cycle S pulse with two entries queued
        rst();
        push1(1'b1, 1'b0);
        push1(1'b1, 1'b1);
        push1(1'b0, 1'b0);
        cmp("t5_S_pre", 1, s[1], 1);
        rst();
        cmp("t5_S", 1, s[1], 0);
        cmp("t5_busy", 1, bsy[1], 0);
        cmp("t5_mq", 1, mq[1], 0);
        for (int i = 0; i < 20; i++) tick();
        cmp("t5_no_s", 1, s_cyc[1], 0);
        cmp("t5_no_r", 1, r_cyc[1], 0);
        cmp("t5_cnt", 1, cnt[1], 0);
        // Random traffic
        rst();
        for (int i = 0; i < 400; i++) begin
            valid = 1'($urandom_range(0, 1));
            level = 1'($urandom_range(0, 1));
            frc = 1'($urandom_range(0, 3) == 0);
            tick();
        end
        valid = 1'b0; frc = 1'b0;
        drain();
`ifdef SRDRV_READBACK_EN
        for (int k = 0; k < 2; k++) cmp("t6_mis_clean", k, mis[k], 0);
        rst();
        fb_zero = 1'b1;
        push1(1'b1, 1'b0);
        drain();
        fb_zero = 1'b0;
        for (int k = 0; k < 2; k++) cmp("t6_mis_set", k, mis[k], 1);
        push1(1'b0, 1'b0);
        drain();
        for (int k = 0; k < 2; k++) cmp("t6_mis_sticky", k, mis[k], 1);
        rst();
        for (int k = 0; k < 2; k++) cmp("t6_mis_cleared", k, mis[k], 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
